// File: rtl/sdp_ram_bytewise_pipelined_pkg.sv
// Shared constants and helpers for the byte-lane simple dual-port RAM.
package sdp_ram_bytewise_pipelined_pkg;

  localparam int unsigned RD_LAT_1         = 1;
  localparam int unsigned RD_LAT_2         = 2;
  localparam int unsigned COLL_WRITE_FIRST = 1;
  localparam int unsigned COLL_READ_FIRST  = 0;

  function automatic int unsigned num_lanes(input int unsigned memory_width,
                                            input int unsigned byte_width);
    return memory_width / byte_width;
  endfunction

endpackage

// File: rtl/sdp_ram_read_pipe.sv
// Output pipeline for the RAM read port: carries {data, valid, collision} for 1 or 2 stages.
module sdp_ram_read_pipe
  import sdp_ram_bytewise_pipelined_pkg::*;
#(
  parameter int unsigned MEMORY_WIDTH = 72,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    rd_valid_i,
  input  logic [MEMORY_WIDTH-1:0] rd_data_i,
  input  logic                    rd_coll_i,
  output logic [MEMORY_WIDTH-1:0] dob_o,
  output logic                    dob_valid_o,
  output logic                    collision_o
);

  logic                    s1_valid_q;
  logic                    s1_coll_q;
  logic [MEMORY_WIDTH-1:0] s1_data_q;

  // Data only loads on a valid beat so the output holds its last word between reads.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid_q <= 1'b0;
      s1_coll_q  <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= rd_valid_i;
      s1_coll_q  <= rd_valid_i & rd_coll_i;
      if (rd_valid_i) begin
        s1_data_q <= rd_data_i;
      end
    end
  end

  if (READ_LATENCY == RD_LAT_2) begin : g_two_stage
    logic                    s2_valid_q;
    logic                    s2_coll_q;
    logic [MEMORY_WIDTH-1:0] s2_data_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        s2_valid_q <= 1'b0;
        s2_coll_q  <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        s2_coll_q  <= s1_valid_q & s1_coll_q;
        if (s1_valid_q) begin
          s2_data_q <= s1_data_q;
        end
      end
    end

    assign dob_o       = s2_data_q;
    assign dob_valid_o = s2_valid_q;
    assign collision_o = s2_coll_q;
  end else begin : g_one_stage
    assign dob_o       = s1_data_q;
    assign dob_valid_o = s1_valid_q;
    assign collision_o = s1_coll_q;
  end

endmodule

// File: rtl/sdp_ram_bytewise_pipelined.sv
// Simple dual-port RAM with per-lane write enables, 1/2-cycle read latency and
// same-address collision handling (write-first or read-first).
module sdp_ram_bytewise_pipelined
  import sdp_ram_bytewise_pipelined_pkg::*;
#(
  parameter  int unsigned MEMORY_WIDTH = 72,
  parameter  int unsigned ADDRS_WIDTH  = 8,
  parameter  int unsigned BYTE_WIDTH   = 9,
  parameter  int unsigned READ_LATENCY = 1,
  parameter  int unsigned BYPASS_EN    = 1,
  localparam int unsigned NUM_LANES    = num_lanes(MEMORY_WIDTH, BYTE_WIDTH),
  localparam int unsigned DEPTH        = 2 ** ADDRS_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    ena_i,
  input  logic [NUM_LANES-1:0]    wea_i,
  input  logic [ADDRS_WIDTH-1:0]  addra_i,
  input  logic [MEMORY_WIDTH-1:0] dia_i,
  input  logic                    enb_i,
  input  logic [ADDRS_WIDTH-1:0]  addrb_i,
  output logic [MEMORY_WIDTH-1:0] dob_o,
  output logic                    dob_valid_o,
  output logic                    collision_o
);

  if ((MEMORY_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
    $error("MEMORY_WIDTH must be an exact multiple of BYTE_WIDTH");
  end
  if ((READ_LATENCY != RD_LAT_1) && (READ_LATENCY != RD_LAT_2)) begin : g_bad_latency
    $error("READ_LATENCY must be 1 or 2");
  end

  logic [MEMORY_WIDTH-1:0] mem_q [DEPTH];
  logic [MEMORY_WIDTH-1:0] rd_old;
  logic [MEMORY_WIDTH-1:0] rd_data;
  logic                    wr_active;
  logic                    rd_coll;
  logic                    rd_valid;

  assign wr_active = ena_i & (|wea_i);
  assign rd_coll   = enb_i & wr_active & (addra_i == addrb_i);
  assign rd_valid  = enb_i & rst_n_i;
  // Array read is taken before this edge's write lands, so it is always the old word.
  assign rd_old    = mem_q[addrb_i];

  // The array is deliberately not reset; contents survive rst_n_i.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && ena_i) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (wea_i[k]) begin
          mem_q[addra_i][k*BYTE_WIDTH +: BYTE_WIDTH] <= dia_i[k*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  always_comb begin
    rd_data = rd_old;
    if ((BYPASS_EN == COLL_WRITE_FIRST) && rd_coll) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (wea_i[k]) begin
          rd_data[k*BYTE_WIDTH +: BYTE_WIDTH] = dia_i[k*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  sdp_ram_read_pipe #(
    .MEMORY_WIDTH(MEMORY_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_read_pipe (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .rd_valid_i (rd_valid),
    .rd_data_i  (rd_data),
    .rd_coll_i  (rd_coll),
    .dob_o      (dob_o),
    .dob_valid_o(dob_valid_o),
    .collision_o(collision_o)
  );

endmodule
